// File: rtl/bus_arbiter_if.sv
// -----------------------------------------------------------------------------
// bus_arbiter_if
//   Downstream system-memory bus between the arbiter and the bus decoder.
//   One transaction: the requester raises bus_request with rw/address/wdata
//   and holds all four stable until the responder raises bus_ready, which
//   also carries bus_rdata for reads.
//
//   Signals
//     bus_request  requester -> responder  transaction pending
//     bus_rw       requester -> responder  1 = write, 0 = read
//     bus_address  requester -> responder  32-bit byte address
//     bus_wdata    requester -> responder  32-bit write data
//     bus_ready    responder -> requester  transaction complete
//     bus_rdata    responder -> requester  32-bit read data, valid with bus_ready
//
//   Modports
//     master  used by the arbiter (drives the request side)
//     slave   used by the decoder / memory model (drives the response side)
// -----------------------------------------------------------------------------
interface bus_arbiter_if;

    logic        bus_request;
    logic        bus_rw;
    logic [31:0] bus_address;
    logic [31:0] bus_wdata;
    logic        bus_ready;
    logic [31:0] bus_rdata;

    modport master (
        output bus_request,
        output bus_rw,
        output bus_address,
        output bus_wdata,
        input  bus_ready,
        input  bus_rdata
    );

    modport slave (
        input  bus_request,
        input  bus_rw,
        input  bus_address,
        input  bus_wdata,
        output bus_ready,
        output bus_rdata
    );

endinterface

// File: rtl/bus_arbiter.sv
// -----------------------------------------------------------------------------
// bus_arbiter
//   Shares one system memory bus between NUM masters (CPU data port, DMA, ...)
//   with round-robin arbitration. A grant is held for one complete
//   request/ready transaction and is never revoked mid-transaction.
//
//   Parameters
//     NUM      number of masters, 2..4; index 0 has the highest priority
//              out of reset
//     TIMEOUT  ACTIVE cycles to wait for bus_ready before aborting
//              (present only when BUS_ARBITER_TIMEOUT_EN is defined)
//
//   Optional feature
//     `define BUS_ARBITER_TIMEOUT_EN adds a watchdog on the ACTIVE state and
//     the sticky o_timeout output. Without it ACTIVE waits for bus_ready
//     indefinitely.
//
//   Ports
//     i_clock     in   1       system clock, rising edge
//     i_reset_n   in   1       asynchronous active-low reset
//     i_request   in   NUM     per-master request, held until its o_ready
//     i_rw        in   NUM     per-master 1 = write, 0 = read
//     i_address   in   NUM*32  master k at [32k+31:32k]
//     i_wdata     in   NUM*32  master k at [32k+31:32k]
//     o_rdata     out  32      read data for the master whose o_ready is high
//     o_ready     out  NUM     per-master completion, one-hot or zero
//     o_stall     out  NUM     high for master k while another master owns
//                              the bus
//     o_timeout   out  1       sticky watchdog flag (timeout build only)
//     bus         bus_arbiter_if.master, downstream request/response
//
//   Sequencing
//     IDLE    -> ACTIVE   some master requests; the winner's fields are
//                         registered onto the bus in the same edge
//     ACTIVE  -> RELEASE  bus_ready (or watchdog expiry); o_ready[grant] set
//     RELEASE -> IDLE     the granted master drops its request; it becomes
//                         `last`, so arbitration restarts after it
//   The RELEASE->IDLE->ACTIVE path guarantees at least one idle bus cycle
//   between grants and bounds any pending master's wait to NUM-1
//   transactions.
// -----------------------------------------------------------------------------
module bus_arbiter #(
    parameter int NUM = 2
`ifdef BUS_ARBITER_TIMEOUT_EN
    ,
    parameter int TIMEOUT = 1024
`endif
) (
    input  logic              i_clock,
    input  logic              i_reset_n,
    input  logic [NUM-1:0]    i_request,
    input  logic [NUM-1:0]    i_rw,
    input  logic [NUM*32-1:0] i_address,
    input  logic [NUM*32-1:0] i_wdata,
    output logic [31:0]       o_rdata,
    output logic [NUM-1:0]    o_ready,
    output logic [NUM-1:0]    o_stall,
`ifdef BUS_ARBITER_TIMEOUT_EN
    output logic              o_timeout,
`endif
    bus_arbiter_if.master     bus
);

    localparam int IDX_W = (NUM > 1) ? $clog2(NUM) : 1;
    localparam logic [IDX_W-1:0] LAST_RESET = IDX_W'(NUM - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACTIVE,
        ST_RELEASE
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [IDX_W-1:0] grant_q;
    logic [IDX_W-1:0] last_q;

    logic             bus_request_q;
    logic             bus_rw_q;
    logic [31:0]      bus_address_q;
    logic [31:0]      bus_wdata_q;
    logic [NUM-1:0]   ready_q;
    logic [31:0]      rdata_q;

    logic             pick_valid;
    logic [IDX_W-1:0] pick_idx;

    // Completion of the ACTIVE transaction and the data returned with it.
    logic             txn_done;
    logic [31:0]      done_rdata;

    // Master index `offset` positions after `base`, wrapping at NUM.
    function automatic logic [IDX_W-1:0] rr_index(input logic [IDX_W-1:0] base,
                                                  input int               offset);
        return IDX_W'((int'(base) + offset) % NUM);
    endfunction

    // -------------------------------------------------------------------------
    // Round-robin pick: scan last+1, last+2, ... last+NUM (last itself comes
    // last), take the first requester.
    // -------------------------------------------------------------------------
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        for (int i = 1; i <= NUM; i++) begin
            if (!pick_valid && i_request[rr_index(last_q, i)]) begin
                pick_valid = 1'b1;
                pick_idx   = rr_index(last_q, i);
            end
        end
    end

    // -------------------------------------------------------------------------
    // Watchdog (optional)
    // -------------------------------------------------------------------------
`ifdef BUS_ARBITER_TIMEOUT_EN
    logic [31:0] wd_count_q;
    logic        timeout_hit;
    logic        timeout_q;

    // The counter holds the number of ACTIVE cycles already spent without
    // bus_ready; expiry fires on the edge that would make it reach TIMEOUT.
    assign timeout_hit = (state_q == ST_ACTIVE) && !bus.bus_ready &&
                         ((wd_count_q + 32'd1) == 32'(TIMEOUT));

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            wd_count_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            if (state_q == ST_IDLE) begin
                wd_count_q <= '0;
            end else if (state_q == ST_ACTIVE) begin
                wd_count_q <= wd_count_q + 32'd1;
            end
            if (timeout_hit) begin
                timeout_q <= 1'b1;
            end
        end
    end

    assign txn_done   = bus.bus_ready || timeout_hit;
    assign done_rdata = bus.bus_ready ? bus.bus_rdata : 32'hDEAD_BEEF;
    assign o_timeout  = timeout_q;
`else
    assign txn_done   = bus.bus_ready;
    assign done_rdata = bus.bus_rdata;
`endif

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    // NOTE: every flop is assigned with <= so all registers update from the
    // same pre-edge values regardless of process ordering.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: default assignment first so no path leaves state_d unassigned,
        // which would otherwise infer a latch.
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    state_d = ST_ACTIVE;
                end
            end
            ST_ACTIVE: begin
                if (txn_done) begin
                    state_d = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                if (!i_request[grant_q]) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Registered datapath: grant, round-robin pointer, bus fields, completion.
    // -------------------------------------------------------------------------
    // NOTE: the bus fields are ordinary flops, not a storage array, and they
    // drive outputs that must read zero during reset, so they get the
    // asynchronous reset like the control state.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            grant_q       <= '0;
            last_q        <= LAST_RESET;
            bus_request_q <= 1'b0;
            bus_rw_q      <= 1'b0;
            bus_address_q <= '0;
            bus_wdata_q   <= '0;
            ready_q       <= '0;
            rdata_q       <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (pick_valid) begin
                        grant_q       <= pick_idx;
                        bus_request_q <= 1'b1;
                        bus_rw_q      <= i_rw[pick_idx];
                        bus_address_q <= i_address[32*pick_idx +: 32];
                        bus_wdata_q   <= i_wdata[32*pick_idx +: 32];
                    end
                end
                ST_ACTIVE: begin
                    // Fields stay frozen until completion; a grant is never
                    // revoked here.
                    if (txn_done) begin
                        bus_request_q    <= 1'b0;
                        ready_q[grant_q] <= 1'b1;
                        rdata_q          <= done_rdata;
                    end
                end
                ST_RELEASE: begin
                    // o_ready is held while the master keeps requesting;
                    // its release also closes the grant.
                    if (!i_request[grant_q]) begin
                        ready_q <= '0;
                        last_q  <= grant_q;
                    end
                end
                default: begin
                    bus_request_q <= 1'b0;
                    ready_q       <= '0;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // FSM: outputs
    // -------------------------------------------------------------------------
    // Stall every master except the owner whenever the bus is not idle.
    always_comb begin
        o_stall = '0;
        for (int j = 0; j < NUM; j++) begin
            o_stall[j] = (state_q != ST_IDLE) && (grant_q != IDX_W'(j));
        end
    end

    assign o_ready         = ready_q;
    assign o_rdata         = rdata_q;
    assign bus.bus_request = bus_request_q;
    assign bus.bus_rw      = bus_rw_q;
    assign bus.bus_address = bus_address_q;
    assign bus.bus_wdata   = bus_wdata_q;

endmodule
